// File: rtl/std_cache_pkg.sv
// Shared types and helpers for the dcache port responder.
// Contents:
//   dcache_port_state_e : responder FSM states (IDLE, WAIT_TAG, RESP)
//   word_index          : byte address -> 64-bit word index
//   sat_inc32           : saturating increment for the event counters
package std_cache_pkg;

  // Largest supported backing store is 512 words, so 9 word-index bits.
  localparam int MAX_WORD_AW = 9;
  localparam int BYTE_ADDR_W = MAX_WORD_AW + 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TAG,
    RESP
  } dcache_port_state_e;

  // Drops the byte-in-word offset. The caller keeps only as many low bits
  // as its memory needs, which makes addresses wrap modulo the depth.
  function automatic logic [MAX_WORD_AW-1:0] word_index(input logic [BYTE_ADDR_W-1:0] byte_addr);
    return MAX_WORD_AW'(byte_addr >> 3);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_port_responder_if.sv
// CPU-side dcache request/response port.
// master : the CPU-side driver (request, tag, kill, write data)
// slave  : the responder (grant, write grant, read data and its valid)
interface dcache_port_responder_if #(
  parameter int INDEX_W = 12,
  parameter int TAG_W   = 44
);

  logic               data_req_i;
  logic               data_we_i;
  logic [INDEX_W-1:0] address_index_i;
  logic [TAG_W-1:0]   address_tag_i;
  logic               tag_valid_i;
  logic               kill_req_i;
  logic [63:0]        data_wdata_i;
  logic [7:0]         data_be_i;
  logic               data_gnt_o;
  logic               data_rvalid_o;
  logic [63:0]        data_rdata_o;
  logic               wr_gnt_o;

  modport master (
    output data_req_i, data_we_i, address_index_i, address_tag_i,
           tag_valid_i, kill_req_i, data_wdata_i, data_be_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, wr_gnt_o
  );

  modport slave (
    input  data_req_i, data_we_i, address_index_i, address_tag_i,
           tag_valid_i, kill_req_i, data_wdata_i, data_be_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, wr_gnt_o
  );

endinterface

// File: rtl/dcache_port_mem.sv
// Backing store for the dcache port responder.
// Ports:
//   clk                               : clock
//   core_we/core_addr/core_wdata/core_be : byte-enabled core write port
//   bd_we/bd_addr/bd_wdata            : full-word backdoor write port
//   rd_addr/rd_data                   : asynchronous read port
// No reset: contents survive a responder reset.
module dcache_port_mem #(
  parameter int MEM_WORDS = 256,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [63:0]   core_wdata,
  input  logic [7:0]    core_be,
  input  logic          bd_we,
  input  logic [AW-1:0] bd_addr,
  input  logic [63:0]   bd_wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [63:0]   rd_data
);

  logic [63:0] mem [MEM_WORDS];
  logic        bd_blocked;

  // A core write to the same word wins outright; the backdoor is dropped.
  assign bd_blocked = core_we && (core_addr == bd_addr);

  always_ff @(posedge clk) begin
    if (bd_we && !bd_blocked) begin
      mem[bd_addr] <= bd_wdata;
    end
    if (core_we) begin
      for (int b = 0; b < 8; b++) begin
        if (core_be[b]) begin
          mem[core_addr][8*b +: 8] <= core_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dcache_port_responder.sv
// Responder model for one CPU-side dcache request/response port.
// Grants requests, takes the deferred read tag, returns read data from an
// internal word memory after RD_LATENCY cycles, commits byte-enabled writes.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   bus (slave)        : request/grant/tag/kill/write/read-data handshake
//   gnt_stall_i        : back-pressure, blocks grants while high
//   bd_we_i/bd_addr_i/bd_wdata_i : backdoor full-word preload
//   rd_cnt_o/wr_cnt_o/kill_cnt_o : saturating event counters
module dcache_port_responder
  import std_cache_pkg::*;
#(
  parameter int INDEX_W    = 12,
  parameter int TAG_W      = 44,
  parameter int MEM_WORDS  = 256,
  parameter int RD_LATENCY = 1,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dcache_port_responder_if.slave bus,
  input  logic                  gnt_stall_i,
  input  logic                  bd_we_i,
  input  logic [AW-1:0]         bd_addr_i,
  input  logic [63:0]           bd_wdata_i,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o,
  output logic [31:0]           kill_cnt_o
);

  // Wide enough to hold both RD_LATENCY and the constant 2 compared below.
  localparam int LAT_W = $clog2(RD_LATENCY + 2);

  dcache_port_state_e   state;
  logic [AW-1:0]        rd_word;
  logic [LAT_W-1:0]     lat_cnt;
  logic                 rvalid_q;
  logic [63:0]          rdata_hold;
  logic [MAX_WORD_AW-1:0] word_full;
  logic [AW-1:0]        req_word;
  logic                 gnt;
  logic                 wr_gnt;
  logic [63:0]          mem_rdata;
  logic                 unused_ok;

  assign word_full = word_index(BYTE_ADDR_W'(bus.address_index_i));
  assign req_word  = word_full[AW-1:0];

  // Grants are combinational so a write completes in its request cycle.
  assign gnt    = (state == IDLE) && bus.data_req_i && !gnt_stall_i;
  assign wr_gnt = gnt && bus.data_we_i;

  dcache_port_mem #(
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk        (clk_i),
    .core_we    (wr_gnt),
    .core_addr  (req_word),
    .core_wdata (bus.data_wdata_i),
    .core_be    (bus.data_be_i),
    .bd_we      (bd_we_i),
    .bd_addr    (bd_addr_i),
    .bd_wdata   (bd_wdata_i),
    .rd_addr    (rd_word),
    .rd_data    (mem_rdata)
  );

  // rvalid_q is raised on the edge entering the final RESP cycle (counter
  // at 1), so it is a registered flag that marks exactly the rvalid cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rd_word    <= '0;
      lat_cnt    <= '0;
      rvalid_q   <= 1'b0;
      rdata_hold <= '0;
      rd_cnt_o   <= '0;
      wr_cnt_o   <= '0;
      kill_cnt_o <= '0;
    end else begin
      if (wr_gnt) begin
        wr_cnt_o <= sat_inc32(wr_cnt_o);
      end
      case (state)
        IDLE: begin
          if (gnt && !bus.data_we_i) begin
            rd_word <= req_word;
            state   <= WAIT_TAG;
          end
        end
        WAIT_TAG: begin
          if (bus.kill_req_i) begin
            kill_cnt_o <= sat_inc32(kill_cnt_o);
            state      <= IDLE;
          end else if (bus.tag_valid_i) begin
            lat_cnt  <= LAT_W'(RD_LATENCY);
            rvalid_q <= (RD_LATENCY == 1);
            state    <= RESP;
          end
        end
        RESP: begin
          if (rvalid_q) begin
            rvalid_q   <= 1'b0;
            rdata_hold <= mem_rdata;
            rd_cnt_o   <= sat_inc32(rd_cnt_o);
            state      <= IDLE;
          end else if (bus.kill_req_i) begin
            kill_cnt_o <= sat_inc32(kill_cnt_o);
            state      <= IDLE;
          end else begin
            lat_cnt  <= lat_cnt - LAT_W'(1);
            rvalid_q <= (lat_cnt == LAT_W'(2));
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory is read live in the rvalid cycle so late backdoor writes show up;
  // outside that cycle the last returned word is held.
  assign bus.data_gnt_o    = gnt;
  assign bus.wr_gnt_o      = wr_gnt;
  assign bus.data_rvalid_o = rvalid_q;
  assign bus.data_rdata_o  = rvalid_q ? mem_rdata : rdata_hold;

  // Tag bits take no part in addressing.
  assign unused_ok = ^{bus.address_tag_i, word_full};

endmodule

// File: tb/tb_dcache_port_responder.sv
// Self-checking bench for dcache_port_responder: one instance with
// RD_LATENCY=1 and one with RD_LATENCY=3, a byte-level memory model per
// instance, and a read-data scoreboard per instance.
module tb_dcache_port_responder;

  localparam int INDEX_W   = 12;
  localparam int TAG_W     = 44;
  localparam int MEM_WORDS = 256;
  localparam int AW        = 8;

  typedef struct {
    logic        req;
    logic        we;
    logic        stall;
    logic [11:0] index;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        expGnt;
    logic        expWrGnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst1, rst3, stall1, stall3, bdWe1, bdWe3;
  logic [AW-1:0] bdAddr1, bdAddr3;
  logic [63:0]   bdData1, bdData3;
  logic [31:0]   rdCnt1, wrCnt1, killCnt1, rdCnt3, wrCnt3, killCnt3;

  dcache_port_responder_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus1 ();
  dcache_port_responder_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus3 ();

  dcache_port_responder #(
    .INDEX_W(INDEX_W), .TAG_W(TAG_W), .MEM_WORDS(MEM_WORDS), .RD_LATENCY(1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst1), .bus(bus1.slave), .gnt_stall_i(stall1),
    .bd_we_i(bdWe1), .bd_addr_i(bdAddr1), .bd_wdata_i(bdData1),
    .rd_cnt_o(rdCnt1), .wr_cnt_o(wrCnt1), .kill_cnt_o(killCnt1)
  );

  dcache_port_responder #(
    .INDEX_W(INDEX_W), .TAG_W(TAG_W), .MEM_WORDS(MEM_WORDS), .RD_LATENCY(3)
  ) dut3 (
    .clk_i(clk), .rst_i(rst3), .bus(bus3.slave), .gnt_stall_i(stall3),
    .bd_we_i(bdWe3), .bd_addr_i(bdAddr3), .bd_wdata_i(bdData3),
    .rd_cnt_o(rdCnt3), .wr_cnt_o(wrCnt3), .kill_cnt_o(killCnt3)
  );

  int          assertCount = 0;
  int          failCount   = 0;
  int          expRd1      = 0;
  int          expWr1      = 0;
  logic [63:0] model1 [MEM_WORDS];
  logic [63:0] model3 [MEM_WORDS];
  logic [63:0] expQ1 [$];
  logic [63:0] expQ3 [$];
  vec_t        vecs [8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int wordOf(input int idx);
    return (idx / 8) % MEM_WORDS;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus1.data_req_i = 0; bus1.data_we_i = 0; bus1.address_index_i = '0;
    bus1.address_tag_i = '0; bus1.tag_valid_i = 0; bus1.kill_req_i = 0;
    bus1.data_wdata_i = '0; bus1.data_be_i = '0;
    bus3.data_req_i = 0; bus3.data_we_i = 0; bus3.address_index_i = '0;
    bus3.address_tag_i = '0; bus3.tag_valid_i = 0; bus3.kill_req_i = 0;
    bus3.data_wdata_i = '0; bus3.data_be_i = '0;
    stall1 = 0; stall3 = 0; bdWe1 = 0; bdWe3 = 0;
    bdAddr1 = '0; bdAddr3 = '0; bdData1 = '0; bdData3 = '0;
  endtask

  task automatic backdoor(input int which, input int word, input logic [63:0] data);
    if (which == 1) begin
      bdWe1 = 1; bdAddr1 = AW'(word); bdData1 = data; model1[word] = data;
    end else begin
      bdWe3 = 1; bdAddr3 = AW'(word); bdData3 = data; model3[word] = data;
    end
    tick();
    bdWe1 = 0; bdWe3 = 0;
  endtask

  // Model of a granted byte-enabled write into the dut1 model.
  task automatic modelWrite1(input logic [11:0] idx, input logic [63:0] data, input logic [7:0] be);
    int w;
    w = wordOf(int'(idx));
    for (int b = 0; b < 8; b++)
      if (be[b]) model1[w][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic applyStimulus(input int n, input vec_t v);
    bus1.data_req_i = v.req; bus1.data_we_i = v.we; stall1 = v.stall;
    bus1.address_index_i = v.index; bus1.data_wdata_i = v.wdata; bus1.data_be_i = v.be;
    #2;
    checkOutput($sformatf("vec%0d gnt", n), {63'd0, bus1.data_gnt_o}, {63'd0, v.expGnt});
    checkOutput($sformatf("vec%0d wr_gnt", n), {63'd0, bus1.wr_gnt_o}, {63'd0, v.expWrGnt});
    if (v.expWrGnt) begin
      modelWrite1(v.index, v.wdata, v.be);
      expWr1++;
    end
    tick();
    clearInputs();
  endtask

  task automatic grantRead1(input logic [11:0] idx);
    bus1.data_req_i = 1; bus1.data_we_i = 0; bus1.address_index_i = idx;
    #2;
    checkOutput("read gnt", {63'd0, bus1.data_gnt_o}, 64'd1);
    checkOutput("read wr_gnt", {63'd0, bus1.wr_gnt_o}, 64'd0);
    tick();
  endtask

  // Tag cycle, rvalid cycle, then one cycle checking rvalid dropped and data held.
  // The request is held high throughout to show no grant leaves IDLE-only.
  task automatic finishRead1(input logic [11:0] idx);
    logic [63:0] expData;
    expData = model1[wordOf(int'(idx))];
    bus1.data_req_i = 1; bus1.data_we_i = 0; bus1.tag_valid_i = 1; bus1.address_tag_i = 44'h1;
    expQ1.push_back(expData);
    #2;
    checkOutput("wait_tag gnt", {63'd0, bus1.data_gnt_o}, 64'd0);
    checkOutput("wait_tag rvalid", {63'd0, bus1.data_rvalid_o}, 64'd0);
    tick();
    bus1.tag_valid_i = 0;
    #2;
    checkOutput("rvalid cycle rvalid", {63'd0, bus1.data_rvalid_o}, 64'd1);
    checkOutput("rvalid cycle gnt", {63'd0, bus1.data_gnt_o}, 64'd0);
    tick();
    bus1.data_req_i = 0;
    expRd1++;
    #2;
    checkOutput("rvalid dropped", {63'd0, bus1.data_rvalid_o}, 64'd0);
    checkOutput("rdata held", bus1.data_rdata_o, expData);
    checkOutput("rd_cnt", {32'd0, rdCnt1}, 64'(expRd1));
    tick();
  endtask

  // dut3: granted read, tag, then cycles until rvalid at T+3.
  task automatic read3(input logic [11:0] idx);
    bus3.data_req_i = 1; bus3.address_index_i = idx;
    #2;
    checkOutput("lat3 gnt", {63'd0, bus3.data_gnt_o}, 64'd1);
    tick();
    bus3.data_req_i = 0; bus3.tag_valid_i = 1;
    expQ3.push_back(model3[wordOf(int'(idx))]);
    tick();
    bus3.tag_valid_i = 0;
    for (int c = 1; c <= 3; c++) begin
      #2;
      checkOutput($sformatf("lat3 rvalid T+%0d", c), {63'd0, bus3.data_rvalid_o}, (c == 3) ? 64'd1 : 64'd0);
      tick();
    end
  endtask

  // Scoreboards: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus1.data_rvalid_o === 1'b1) begin
      if (expQ1.size() == 0) checkOutput("dut1 unexpected rvalid", {63'd0, bus1.data_rvalid_o}, 64'd0);
      else checkOutput("dut1 rdata", bus1.data_rdata_o, expQ1.pop_front());
    end
    if (bus3.data_rvalid_o === 1'b1) begin
      if (expQ3.size() == 0) checkOutput("dut3 unexpected rvalid", {63'd0, bus3.data_rvalid_o}, 64'd0);
      else checkOutput("dut3 rdata", bus3.data_rdata_o, expQ3.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 12'h000, 64'h0,                   8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 12'h010, 64'h11223344_55667788,   8'h0F, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 12'h010, 64'h11223344_55667788,   8'h0F, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 12'h018, 64'h55555555_55555555,   8'h00, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 12'h020, 64'h99887766_00000000,   8'hF0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 12'h028, 64'h0,                   8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 12'h020, 64'hFFFFFFFF_FFFFFFFF,   8'hFF, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 12'h81F, 64'h00000000_000000EE,   8'h01, 1'b1, 1'b1};

    clearInputs();
    rst1 = 1; rst3 = 1;
    tick();
    tick();
    rst1 = 0; rst3 = 0;
    #2;
    $display("[TB] reset state");
    checkOutput("reset gnt", {63'd0, bus1.data_gnt_o}, 64'd0);
    checkOutput("reset wr_gnt", {63'd0, bus1.wr_gnt_o}, 64'd0);
    checkOutput("reset rvalid", {63'd0, bus1.data_rvalid_o}, 64'd0);
    checkOutput("reset rdata", bus1.data_rdata_o, 64'd0);
    checkOutput("reset counters", {rdCnt1 | wrCnt1 | killCnt1, 32'd0}, 64'd0);
    checkOutput("reset rdata dut3", bus3.data_rdata_o, 64'd0);
    tick();

    backdoor(1, 5, 64'hDEADBEEF_CAFEF00D);
    backdoor(1, 2, 64'hFFFFFFFF_FFFFFFFF);
    backdoor(1, 3, 64'h01234567_89ABCDEF);
    backdoor(1, 4, 64'hAAAAAAAA_BBBBBBBB);
    backdoor(1, 0, 64'h0BADC0DE_12345678);
    backdoor(1, 6, 64'h0);

    $display("[TB] basic read, latency 1");
    grantRead1(12'h028);
    finishRead1(12'h028);

    $display("[TB] table-driven IDLE vectors");
    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);
    #2;
    checkOutput("wr_cnt after table", {32'd0, wrCnt1}, 64'(expWr1));
    tick();
    grantRead1(12'h010); finishRead1(12'h010);
    grantRead1(12'h018); finishRead1(12'h018);
    grantRead1(12'h020); finishRead1(12'h020);

    $display("[TB] kill with simultaneous tag");
    grantRead1(12'h028);
    bus1.kill_req_i = 1; bus1.tag_valid_i = 1;
    tick();
    clearInputs();
    bus1.data_req_i = 1; bus1.address_index_i = 12'h020;
    #2;
    checkOutput("killed rvalid", {63'd0, bus1.data_rvalid_o}, 64'd0);
    checkOutput("gnt after kill", {63'd0, bus1.data_gnt_o}, 64'd1);
    checkOutput("kill_cnt", {32'd0, killCnt1}, 64'd1);
    tick();
    finishRead1(12'h020);

    $display("[TB] stalled write, colliding backdoor on grant");
    bus1.data_req_i = 1; bus1.data_we_i = 1; bus1.address_index_i = 12'h030;
    bus1.data_wdata_i = 64'hC0FFEE00_12345678; bus1.data_be_i = 8'hFF; stall1 = 1;
    for (int c = 0; c < 3; c++) begin
      #2;
      checkOutput($sformatf("stall%0d gnt", c), {63'd0, bus1.data_gnt_o}, 64'd0);
      checkOutput($sformatf("stall%0d wr_cnt", c), {32'd0, wrCnt1}, 64'(expWr1));
      tick();
    end
    stall1 = 0; bdWe1 = 1; bdAddr1 = 8'd6; bdData1 = 64'hBADBADBA_DBADBADB;
    #2;
    checkOutput("unstall gnt", {63'd0, bus1.data_gnt_o}, 64'd1);
    checkOutput("unstall wr_gnt", {63'd0, bus1.wr_gnt_o}, 64'd1);
    modelWrite1(12'h030, 64'hC0FFEE00_12345678, 8'hFF);
    expWr1++;
    tick();
    clearInputs();
    #2;
    checkOutput("wr_cnt after stall", {32'd0, wrCnt1}, 64'(expWr1));
    tick();
    grantRead1(12'h030); finishRead1(12'h030);

    $display("[TB] index wrap-around");
    grantRead1(12'h800); finishRead1(12'h800);

    $display("[TB] latency 3: reset mid-read");
    backdoor(3, 7, 64'h77777777_77777777);
    bus3.data_req_i = 1; bus3.address_index_i = 12'h038;
    tick();
    bus3.data_req_i = 0; bus3.tag_valid_i = 1;
    tick();
    bus3.tag_valid_i = 0; rst3 = 1;
    tick();
    rst3 = 0;
    for (int c = 0; c < 4; c++) begin
      #2;
      checkOutput("post-reset rvalid", {63'd0, bus3.data_rvalid_o}, 64'd0);
      tick();
    end
    checkOutput("post-reset counters", {rdCnt3 | wrCnt3 | killCnt3, 32'd0}, 64'd0);
    read3(12'h038);
    #2;
    checkOutput("lat3 rd_cnt", {32'd0, rdCnt3}, 64'd1);
    tick();

    $display("[TB] latency 3: kill in RESP");
    bus3.data_req_i = 1; bus3.address_index_i = 12'h038;
    tick();
    bus3.data_req_i = 0; bus3.tag_valid_i = 1;
    tick();
    bus3.tag_valid_i = 0; bus3.kill_req_i = 1;
    tick();
    bus3.kill_req_i = 0;
    for (int c = 0; c < 4; c++) begin
      #2;
      checkOutput("resp-kill rvalid", {63'd0, bus3.data_rvalid_o}, 64'd0);
      tick();
    end
    checkOutput("lat3 kill_cnt", {32'd0, killCnt3}, 64'd1);
    checkOutput("lat3 rd_cnt after kill", {32'd0, rdCnt3}, 64'd1);

    $display("[TB] latency 3: backdoor write just before rvalid");
    bus3.data_req_i = 1; bus3.address_index_i = 12'h038;
    tick();
    bus3.data_req_i = 0; bus3.tag_valid_i = 1;
    tick();
    bus3.tag_valid_i = 0;
    tick();
    bdWe3 = 1; bdAddr3 = 8'd7; bdData3 = 64'h13579BDF_2468ACE0;
    expQ3.push_back(64'h13579BDF_2468ACE0);
    tick();
    bdWe3 = 0;
    #2;
    checkOutput("late bd rvalid", {63'd0, bus3.data_rvalid_o}, 64'd1);
    tick();
    checkOutput("lat3 rd_cnt final", {32'd0, rdCnt3}, 64'd2);

    tick();
    checkOutput("dut1 scoreboard drained", 64'(expQ1.size()), 64'd0);
    checkOutput("dut3 scoreboard drained", 64'(expQ3.size()), 64'd0);
    checkOutput("dut1 final rd_cnt", {32'd0, rdCnt1}, 64'(expRd1));
    checkOutput("dut1 final wr_cnt", {32'd0, wrCnt1}, 64'(expWr1));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
